seg16_scroll_ctrl: RTL and testbench
====================================

# seg16_scroll_ctrl

Message sequencer that sits in front of the six-character 16-segment decoder. It accepts an ASCII message over a valid/ready byte stream and stores it in an internal buffer. It then drives the six character inputs of the decoder with a six-character window that scrolls through the message with wrap-around, at a programmable step rate. Messages of six characters or fewer are shown statically, padded with spaces.

## Interface
- `DEPTH`, 16: message buffer capacity in characters; power of two, at least 8.
- `STEP_W`, 24: width of the step-interval counter.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `step_div` in STEP_W: cycles per scroll step minus 1; sampled live every cycle.
- `wr_valid` in 1: write beat valid.
- `wr_ready` out 1: write beat accepted when `wr_valid && wr_ready`.
- `wr_char` in 8: ASCII character of the beat.
- `wr_last` in 1: marks the final character of the message.
- `clear` in 1: single-cycle command; abandons the current message.
- `busy` out 1: high in LOAD and RUN.
- `step_strobe` out 1: one-cycle pulse on each scroll step.
- `char1`..`char6` out 8 each: ASCII to the decoder; `char1` is leftmost.

## Operation
- Buffer: `DEPTH` x 8 registers. Length `len` has width clog2(DEPTH)+1. Window offset `pos` ranges 0..len-1. Step counter `cnt` has width STEP_W.
- States are IDLE, LOAD and RUN. `wr_ready` is decoded from state only: 1 in IDLE and LOAD, 0 in RUN.
- IDLE:
  - All `charK` = 8'h20 (space).
  - An accepted beat writes buf[0] and sets len=1.
  - Next state is RUN if `wr_last` is set, else LOAD.
- LOAD:
  - Each accepted beat writes buf[len] and increments len.
  - Go to RUN when the beat has `wr_last` set, or when it is the DEPTH-th character (implicit last).
  - `charK` stay at space.
- RUN:
  - `cnt` counts 0..step_div. When cnt==step_div and cnt is at its terminal value:
    - `cnt` returns to 0.
    - `step_strobe` pulses.
    - If len>6, pos advances: pos = (pos==len-1) ? 0 : pos+1.
    - If len<=6, pos stays 0, but `step_strobe` still pulses.
  - Display, len>6: charK = buf[idx] with idx = pos+K-1, minus len if idx>=len. A single conditional subtract is sufficient because pos<len and K-1<=5<len.
  - Display, len<=6: charK = buf[K-1] for K<=len, else 8'h20.
  - If `step_div` decreases below the current `cnt`, the counter runs to wrap. It matches the new value on the next pass and no step is taken in between.
- `clear` from any state goes to IDLE with len=0, pos=0, cnt=0. Blank characters appear on the next output update. `clear` has priority over a same-cycle accepted beat; that beat is consumed and discarded.
- Buffer contents are not cleared by `rst` or `clear`. Entries at or beyond `len` are never displayed.

## Timing
- Reset values (after any edge with rst=1):
  - state IDLE; len 0; pos 0; cnt 0.
  - `char1`..`char6` = 8'h20.
  - `step_strobe` 0; `busy` 0; `wr_ready` 1.
- `rst` overrides `clear` and all other inputs, including mid-LOAD and mid-RUN.
- `charK` are registered and computed from the registered state, len, pos and buffer. They lag those registers by one cycle.
- Final beat accepted at edge E:
  - state=RUN, pos=0 and cnt=0 after E.
  - `charK` show the pos-0 window after E+1.
  - First `step_strobe` is high in the cycle after edge E+step_div.
  - pos increments at edge E+step_div+1.
  - New window is visible after E+step_div+2.
- With step_div=0, the window steps every cycle.
- `busy` and `step_strobe` are registered outputs.
- Throughput is one write beat per cycle in IDLE and LOAD.

## Test plan
- **Reset:** hold rst 2 cycles with random inputs. Require all `charK`=8'h20, `wr_ready`=1, `busy`=0 and `step_strobe`=0. Then assert rst mid-RUN and require the same values after that edge.
- **Short message:** write "ABC" (41,42,43, last on 43) with step_div=3. Require `char1`..`char6` = 41,42,43,20,20,20, unchanged across 3 strobes spaced 4 cycles apart.
- **Scroll and wrap:** write "ABCDEFGH" with step_div=0. Require successive windows ABCDEF, BCDEFG, CDEFGH, DEFGHA, EFGHAB, FGHABC, GHABCD, HABCDE, then ABCDEF again.
- **Full buffer:** write 16 chars "A".."P" with no `wr_last`. Require RUN after the 16th beat, `wr_ready`=0, and window "PABCDE" at pos=15.
- **Clear:**
  - `clear` during LOAD (after 3 chars): require IDLE and spaces.
  - `clear` in the same cycle as an accepted beat: require the beat discarded; a following message "XYZ" then displays 58,59,5A,20,20,20.
- **Live step_div change:** in RUN with step_div=9 and cnt=6, set step_div=3. Require no step until cnt wraps; steps then occur every 4 cycles.

Source files
------------

// File: rtl/seg16_scroll_ctrl.sv
// Message sequencer for the six-character 16-segment decoder: buffers an
// ASCII message from a byte stream and scrolls a six-character window over it.
module seg16_scroll_ctrl #(
    parameter int DEPTH  = 16,
    parameter int STEP_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STEP_W-1:0] step_div,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_char,
    input  logic              wr_last,
    input  logic              clear,
    output logic              busy,
    output logic              step_strobe,
    output logic [7:0]        char1,
    output logic [7:0]        char2,
    output logic [7:0]        char3,
    output logic [7:0]        char4,
    output logic [7:0]        char5,
    output logic [7:0]        char6
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state;
    logic [LW-1:0]     len;
    logic [AW-1:0]     pos;
    logic [STEP_W-1:0] cnt;
    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic              last_beat;
    logic              at_term;
    logic [STEP_W-1:0] cnt_inc;
    logic [AW-1:0]     pos_next;
    logic [LW-1:0]     idx [6];
    logic [7:0]        win [6];

    assign wr_ready  = (state != RUN);
    assign accept    = wr_valid && wr_ready;
    // The DEPTH-th character closes the message even without wr_last
    assign last_beat = wr_last || (len == LW'(DEPTH - 1));
    assign at_term   = (cnt == step_div);
    assign cnt_inc   = cnt + STEP_W'(1);
    assign pos_next  = (LW'(pos) == len - LW'(1)) ? '0 : pos + AW'(1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= IDLE;
            len         <= '0;
            pos         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
        end else begin
            unique case (state)
                IDLE, LOAD: begin
                    step_strobe <= 1'b0;
                    if (accept) begin
                        len  <= len + LW'(1);
                        busy <= 1'b1;
                        if (last_beat) begin
                            state       <= RUN;
                            pos         <= '0;
                            cnt         <= '0;
                            step_strobe <= (step_div == '0);
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                RUN: begin
                    // Strobe is high while cnt sits on its terminal value
                    if (at_term) begin
                        cnt         <= '0;
                        step_strobe <= (step_div == '0);
                        if (len > LW'(6)) begin
                            pos <= pos_next;
                        end
                    end else begin
                        cnt         <= cnt_inc;
                        step_strobe <= (cnt_inc == step_div);
                    end
                end
                default: begin
                    state       <= IDLE;
                    len         <= '0;
                    pos         <= '0;
                    cnt         <= '0;
                    busy        <= 1'b0;
                    step_strobe <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !clear && !rst) begin
            mem[len[AW-1:0]] <= wr_char;
        end
    end

    // pos < len and k <= 5 < len, so one subtract folds the index back
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            idx[k] = LW'(pos) + LW'(k);
            if (idx[k] >= len) begin
                idx[k] = idx[k] - len;
            end
            win[k] = SPACE;
            if (state == RUN) begin
                if (len > LW'(6)) begin
                    win[k] = mem[idx[k][AW-1:0]];
                end else if (LW'(k) < len) begin
                    win[k] = mem[AW'(k)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char1 <= SPACE;
            char2 <= SPACE;
            char3 <= SPACE;
            char4 <= SPACE;
            char5 <= SPACE;
            char6 <= SPACE;
        end else begin
            char1 <= win[0];
            char2 <= win[1];
            char3 <= win[2];
            char4 <= win[3];
            char5 <= win[4];
            char6 <= win[5];
        end
    end

endmodule

// File: tb/tb_seg16_scroll_ctrl.sv
// Bench for seg16_scroll_ctrl: queue-based message model checked every cycle,
// directed scenarios with literal windows, then randomized traffic.
module tb_seg16_scroll_ctrl;

    localparam int DEPTH = 16;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] step_div;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    wr_char;
    logic          wr_last;
    logic          clear;
    logic          busy;
    logic          step_strobe;
    logic [7:0]    char1, char2, char3, char4, char5, char6;
    logic [47:0]   chars_q;

    always #5 clk = ~clk;

    assign chars_q = {char1, char2, char3, char4, char5, char6};

    seg16_scroll_ctrl #(.DEPTH(DEPTH), .STEP_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .step_div    (step_div),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_char     (wr_char),
        .wr_last     (wr_last),
        .clear       (clear),
        .busy        (busy),
        .step_strobe (step_strobe),
        .char1       (char1),
        .char2       (char2),
        .char3       (char3),
        .char4       (char4),
        .char5       (char5),
        .char6       (char6)
    );

    localparam logic [47:0] WIN [9] = '{
        "ABCDEF", "BCDEFG", "CDEFGH", "DEFGHA", "EFGHAB",
        "FGHABC", "GHABCD", "HABCDE", "ABCDEF"
    };

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model: mode 0 idle, 1 loading, 2 showing
    int         m_mode = 0;
    logic [7:0] m_msg[$];
    int         m_pos = 0;
    int         m_cnt = 0;
    bit         m_strobe = 0;
    logic [7:0] exp_ch [6];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_char(int k);
        int n;
        n = m_msg.size();
        if (m_mode != 2) return 8'h20;
        if (n > 6) return m_msg[(m_pos + k) % n];
        if (k < n) return m_msg[k];
        return 8'h20;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 6; k++) exp_ch[k] = rst ? 8'h20 : m_char(k);
        if (rst || clear) begin
            m_mode = 0;
            m_msg.delete();
            m_pos = 0;
            m_cnt = 0;
        end else if (m_mode != 2) begin
            if (wr_valid) begin
                m_msg.push_back(wr_char);
                if (wr_last || m_msg.size() == DEPTH) begin
                    m_mode = 2;
                    m_pos  = 0;
                    m_cnt  = 0;
                end else begin
                    m_mode = 1;
                end
            end
        end else begin
            if (m_cnt == int'(step_div)) begin
                m_cnt = 0;
                if (m_msg.size() > 6) m_pos = (m_pos + 1) % m_msg.size();
            end else begin
                m_cnt = (m_cnt + 1) % (1 << SW);
            end
        end
        m_strobe = (m_mode == 2) && (m_cnt == int'(step_div));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk_en = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("chars", chars_q, {exp_ch[0], exp_ch[1], exp_ch[2],
                                     exp_ch[3], exp_ch[4], exp_ch[5]});
            check("strobe", step_strobe, m_strobe);
            check("busy", busy, m_mode != 0);
            check("wr_ready", wr_ready, m_mode != 2);
        end
    end

    task automatic send(logic [7:0] c, bit last);
        wr_valid = 1'b1;
        wr_char  = c;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    int  strobes;
    bit  same;

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_char  = 8'h00;
        wr_last  = 1'b0;
        step_div = 3;

        repeat (2) begin
            wr_valid = 1'($urandom);
            wr_char  = 8'($urandom);
            wr_last  = 1'($urandom);
            clear    = 1'($urandom);
            step_div = SW'($urandom);
            tick();
        end
        rst = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        check("rst_chars", chars_q, 48'h202020202020);
        check("rst_ready", wr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_strobe", step_strobe, 0);

        // Short static message
        step_div = 3;
        send(8'h41, 0); send(8'h42, 0); send(8'h43, 1);
        tick();
        check("short_win", chars_q, 48'h414243202020);
        strobes = 0;
        same = 1;
        repeat (11) begin
            tick();
            strobes += int'(step_strobe);
            if (chars_q !== 48'h414243202020) same = 0;
        end
        check("short_strobes", strobes, 3);
        check("short_static", same, 1);

        // Reset in the middle of RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrun_chars", chars_q, 48'h202020202020);
        check("rrun_ready", wr_ready, 1);
        check("rrun_busy", busy, 0);
        check("rrun_strobe", step_strobe, 0);

        // Scroll and wrap
        step_div = 0;
        for (int i = 0; i < 8; i++) send(8'(8'h41 + i), i == 7);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("scroll%0d", i), chars_q, WIN[i]);
        end

        // Full buffer with implicit last
        do_clear();
        for (int i = 0; i < 16; i++) send(8'(8'h41 + i), 0);
        check("full_ready", wr_ready, 0);
        check("full_busy", busy, 1);
        repeat (16) tick();
        check("full_wrap", chars_q, "PABCDE");

        // Clear during LOAD
        do_clear();
        send(8'h61, 0); send(8'h62, 0); send(8'h63, 0);
        do_clear();
        check("clr_busy", busy, 0);
        check("clr_ready", wr_ready, 1);
        tick();
        check("clr_chars", chars_q, 48'h202020202020);

        // Clear colliding with an accepted beat
        wr_valid = 1'b1; wr_char = 8'h51; clear = 1'b1;
        tick();
        wr_valid = 1'b0; clear = 1'b0;
        check("clrbeat_busy", busy, 0);
        send(8'h58, 0); send(8'h59, 0); send(8'h5A, 1);
        tick();
        check("xyz_win", chars_q, 48'h58595A202020);

        // Live step_div decrease below cnt
        do_clear();
        step_div = 9;
        for (int i = 0; i < 8; i++) send(8'(8'h41 + i), i == 7);
        repeat (6) tick();
        step_div = 3;
        strobes = 0;
        repeat (250) begin
            tick();
            strobes += int'(step_strobe);
        end
        check("live_nostep", strobes, 0);
        strobes = 0;
        repeat (16) begin
            tick();
            strobes += int'(step_strobe);
        end
        check("live_steps", strobes, 4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom % 300) == 0;
            clear    = ($urandom % 60) == 0;
            wr_valid = ($urandom % 3) != 0;
            wr_char  = 8'(8'h20 + $urandom % 95);
            wr_last  = ($urandom % 7) == 0;
            if ($urandom % 100 == 0) step_div = SW'($urandom % 6);
            tick();
        end
        rst = 1'b0; clear = 1'b0; wr_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
